// File: rtl/sipo_framer.sv
// Serial-in, parallel-out word assembler with frame realignment, a one-word
// holding register behind a valid/ready handshake, and a sticky overrun flag.
module sipo_framer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_bit_word;
  logic             complete;
  logic             ovr_set;

  // Shifted word including the incoming bit, and a word holding only a new first bit.
  always_comb begin
    shifted        = '0;
    first_bit_word = '0;
    if (MSB_FIRST) begin
      shifted        = {shift_q[WIDTH-2:0], sin};
      first_bit_word = {{(WIDTH-1){1'b0}}, sin};
    end else begin
      shifted        = {sin, shift_q[WIDTH-1:1]};
      first_bit_word = {sin, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    ovr_set  = 1'b0;
    complete = 1'b0;

    if (frame_start) begin
      shift_d = sin_valid ? first_bit_word : '0;
      cnt_d   = sin_valid ? CNT_W'(1) : '0;
    end else if (sin_valid) begin
      if (cnt_q == LAST_CNT) begin
        complete = 1'b1;
        shift_d  = '0;
        cnt_d    = '0;
      end else begin
        shift_d  = shifted;
        cnt_d    = cnt_q + CNT_W'(1);
      end
    end

    // A completed word only displaces the holding register if it is empty or draining now.
    if (complete) begin
      if (!valid_q || dout_ready) begin
        dout_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end

    ovr_d = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      shift_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign bit_cnt    = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: doc/sipo_framer.md
Name: sipo_framer

Overview:
- Parameterised serial-in, parallel-out deserializer with bit-order select, frame realignment and a valid/ready output handshake.
- Accepts one serial bit per qualified clock and assembles WIDTH-bit words.
- Each completed word is presented in a holding register until the downstream consumer takes it.
- Sits between a serial receive front-end and any word-wide consumer (FIFO, register file, decoder).

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0].
- CNT_W, $clog2(WIDTH), width of the bit counter; derived, do not override.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_  input  1  synchronous, active-high reset (sampled on rising clk; rst_=1 resets).
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is accepted on a rising edge when this is 1.
- frame_start  input  1  discards any partial word; the bit accepted in the same cycle (if any) becomes bit 0 of a new word.
- dout  output  WIDTH  assembled word in the holding register.
- dout_valid  output  1  holding register contains an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready on a rising edge.
- bit_cnt  output  CNT_W  number of bits collected in the current partial word (0..WIDTH-1).
- overrun  output  1  sticky flag: a completed word was dropped because the holding register was still full.
- ovr_clr  input  1  clears overrun.

Behaviour:
- Reset (rst_=1 at a clock edge), takes priority over everything:
  - shift register, dout, dout_valid, bit_cnt and overrun all go to 0.
  - All inputs in that cycle are ignored.
- Shift register (internal, WIDTH bits), on each accepted bit:
  - MSB_FIRST=1: shift left, sin enters at bit 0.
  - MSB_FIRST=0: shift right, sin enters at bit WIDTH-1.
  - After WIDTH bits, the first bit sits at the position stated under Parameters.
- bit_cnt:
  - Increments on each accepted bit.
  - Wraps WIDTH-1 -> 0 on the bit that completes a word.
  - Unaccepted cycles (sin_valid=0) leave the shift register and bit_cnt unchanged.
- frame_start=1 without sin_valid: bit_cnt -> 0, shift register -> 0, partial word discarded.
- frame_start=1 with sin_valid:
  - bit_cnt -> 1, and sin is the first bit of the new word.
  - With WIDTH bits per word this never completes a word (WIDTH>=2).
- Word completion: the accepted bit with bit_cnt==WIDTH-1 (and frame_start=0) completes a word.
  - The full word, including this bit, is written to dout on the same edge.
  - dout_valid=1 from the next cycle; latency is one clock from the last bit's edge to dout visible.
- Handshake:
  - dout and dout_valid hold steady while dout_valid && !dout_ready.
  - On dout_valid && dout_ready with no completion in that cycle: dout_valid -> 0 and dout keeps its last value.
- Simultaneous completion and handshake (dout_valid && dout_ready && completion):
  - New word loads into dout, dout_valid stays 1, no overrun.
- Completion while dout_valid && !dout_ready:
  - New word is dropped, dout is unchanged, overrun -> 1.
  - Shift register and bit_cnt still restart for the next word.
- overrun:
  - Stays 1 until ovr_clr=1 or reset.
  - ovr_clr together with a new overrun event in the same cycle: overrun stays 1 (set wins).
- Bits are never back-pressured: sin has no ready signal, and loss is reported only via overrun.
- Reset mid-word or with a word pending: everything is lost, and the next accepted bit is bit 0 of a new word.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, MSB_FIRST=1, WIDTH=8: after rst_ pulse, all outputs 0. Hold dout_ready=1 and send bits 0,0,0,1,1,1,1,1 on consecutive cycles -> dout=0x1F, dout_valid=1 for exactly one cycle, one clock after the 8th bit; bit_cnt returns to 0.
- MSB_FIRST=0, same bit sequence -> dout=0xF8.
- Gapped input: sin_valid toggles 1,0,1,0,... across 16 cycles carrying 8 bits of 0xA5 MSB-first -> bit_cnt advances only on valid cycles; dout=0xA5.
- Back-pressure, dout_ready=0:
  - Send 0x3C then 0x81 -> dout stays 0x3C, overrun=1 after the 16th bit.
  - Assert ovr_clr -> overrun=0.
  - Assert dout_ready -> dout_valid drops.
- Back-to-back with simultaneous handshake: pending 0x3C, dout_ready=1 on the edge that completes 0x55 -> dout=0x55, dout_valid stays 1, overrun=0.
- Realignment: send 3 bits, then frame_start=1 with sin_valid=1 and sin=1, then 7 more bits 0,0,0,0,0,0,1 (MSB-first) -> dout=0x81. Separately, assert rst_ after 5 bits -> bit_cnt=0, no word emitted.
